// File: rtl/memory_map_pkg.sv
// Address map, region decode and reset constants shared by memory_responder.
// The timer decode is enabled by the caller (see MEMORY_RESPONDER_TIMER_EN).
package memory_map_pkg;

  localparam logic [31:0] RAM_BASE_ADDRESS = 32'h0000_0000;
  localparam logic [31:0] GPIO_OUT_ADDRESS = 32'h8000_0000;
  localparam logic [31:0] GPIO_IN_ADDRESS  = 32'h8000_0004;
  localparam logic [31:0] TIMER_ADDRESS    = 32'h8000_0008;
  localparam logic [31:0] COMPARE_ADDRESS  = 32'h8000_000C;

  localparam logic [31:0] WORD_MASK     = 32'hFFFF_FFFC;
  localparam logic [31:0] COMPARE_RESET = '1;

  typedef enum logic [2:0] {
    RAM,
    GPIO_OUT,
    GPIO_IN,
    TIMER,
    COMPARE,
    UNMAPPED
  } region_t;

  // ram_bytes_log2 is log2 of the RAM size in bytes; byte-lane bits are ignored everywhere.
  function automatic region_t decode_region(input logic [31:0] addr,
                                            input int unsigned ram_bytes_log2,
                                            input logic timer_en);
    logic [31:0] word;
    region_t     r;
    word = addr & WORD_MASK;
    r    = UNMAPPED;
    if ((addr >> ram_bytes_log2) == (RAM_BASE_ADDRESS >> ram_bytes_log2)) begin
      r = RAM;
    end else if (word == GPIO_OUT_ADDRESS) begin
      r = GPIO_OUT;
    end else if (word == GPIO_IN_ADDRESS) begin
      r = GPIO_IN;
    end else if (timer_en && (word == TIMER_ADDRESS)) begin
      r = TIMER;
    end else if (timer_en && (word == COMPARE_ADDRESS)) begin
      r = COMPARE;
    end
    return r;
  endfunction

endpackage

// File: rtl/memory_responder_synchronizer.sv
// Two-flop synchronizer for asynchronous inputs, asynchronous active-low reset.
module synchronizer #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/memory_responder.sv
// Memory-bus target: word RAM, GPIO registers and optional cycle timer with compare IRQ.
// Timer/compare registers are built only when MEMORY_RESPONDER_TIMER_EN is defined.
module memory_responder #(
  parameter int unsigned NUM_WORDS  = 64,
  parameter int unsigned GPIO_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [31:0]           address,
  input  logic                  write_enable,
  input  logic [31:0]           write_data,
  output logic [31:0]           read_data,
  input  logic [GPIO_WIDTH-1:0] gpio_in,
  output logic [GPIO_WIDTH-1:0] gpio_out,
  output logic                  timer_irq,
  output logic                  bus_error
);

  import memory_map_pkg::*;

  localparam int unsigned AW = $clog2(NUM_WORDS);
`ifdef MEMORY_RESPONDER_TIMER_EN
  localparam logic TIMER_EN = 1'b1;
`else
  localparam logic TIMER_EN = 1'b0;
`endif

  region_t               region;
  logic [AW-1:0]         ram_idx;
  logic [31:0]           mem_q [NUM_WORDS];
  logic [GPIO_WIDTH-1:0] gpio_in_sync;
  logic [GPIO_WIDTH-1:0] gpio_out_q, gpio_out_d;
  logic                  bus_error_q, bus_error_d;
  logic [31:0]           timer_rdata, compare_rdata;

  always_comb region = decode_region(address, AW + 2, TIMER_EN);
  assign ram_idx = address[AW+1:2];

  // RAM has no reset; a write coinciding with reset assertion is dropped.
  always_ff @(posedge clock) begin
    if (reset && write_enable && (region == RAM)) begin
      mem_q[ram_idx] <= write_data;
    end
  end

  synchronizer #(
    .WIDTH(GPIO_WIDTH)
  ) u_gpio_sync (
    .clk_i (clock),
    .rst_ni(reset),
    .d_i   (gpio_in),
    .q_o   (gpio_in_sync)
  );

  always_comb begin
    gpio_out_d  = gpio_out_q;
    bus_error_d = bus_error_q;
    if (write_enable) begin
      if (region == GPIO_OUT) gpio_out_d = write_data[GPIO_WIDTH-1:0];
      if (region == UNMAPPED) bus_error_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      gpio_out_q  <= '0;
      bus_error_q <= 1'b0;
    end else begin
      gpio_out_q  <= gpio_out_d;
      bus_error_q <= bus_error_d;
    end
  end

`ifdef MEMORY_RESPONDER_TIMER_EN
  logic [31:0] timer_q, timer_d;
  logic [31:0] compare_q, compare_d;
  logic        irq_q, irq_d;

  // A compare write clears the flag even when a match occurs in the same cycle.
  always_comb begin
    timer_d   = timer_q + 32'd1;
    compare_d = compare_q;
    irq_d     = irq_q | (timer_q == compare_q);
    if (write_enable) begin
      if (region == TIMER) timer_d = write_data;
      if (region == COMPARE) begin
        compare_d = write_data;
        irq_d     = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      timer_q   <= '0;
      compare_q <= COMPARE_RESET;
      irq_q     <= 1'b0;
    end else begin
      timer_q   <= timer_d;
      compare_q <= compare_d;
      irq_q     <= irq_d;
    end
  end

  assign timer_rdata   = timer_q;
  assign compare_rdata = compare_q;
  assign timer_irq     = irq_q;
`else
  assign timer_rdata   = '0;
  assign compare_rdata = '0;
  assign timer_irq     = 1'b0;
`endif

  always_comb begin
    read_data = '0;
    case (region)
      RAM:      read_data = mem_q[ram_idx];
      GPIO_OUT: read_data = 32'(gpio_out_q);
      GPIO_IN:  read_data = 32'(gpio_in_sync);
      TIMER:    read_data = timer_rdata;
      COMPARE:  read_data = compare_rdata;
      default:  read_data = '0;
    endcase
  end

  assign gpio_out  = gpio_out_q;
  assign bus_error = bus_error_q;

endmodule

// File: doc/memory_responder.md
# memory_responder

Target end of the CPU's simple memory bus: services single-cycle word accesses from the core's load/store path. Holds word-addressed data RAM, a memory-mapped GPIO block and an optional cycle timer with compare interrupt. Sits beside the `cpu` instance at top level, wired directly to its `address`/`write_enable`/`write_data`/`read_data` pins.

## Interface

**Parameters**
- `NUM_WORDS`, default 64: RAM depth in 32-bit words; power of two, at least 4.
- `GPIO_WIDTH`, default 8: width of the GPIO in/out ports, 1 to 32.

**Ports**
- `clock` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `address` input 32: byte address from the CPU.
- `write_enable` input 1: write strobe, qualified by `clock`.
- `write_data` input 32: store data.
- `read_data` output 32: load data, combinational from `address`.
- `gpio_in` input GPIO_WIDTH: asynchronous external inputs.
- `gpio_out` output GPIO_WIDTH: registered outputs.
- `timer_irq` output 1: sticky timer compare flag.
- `bus_error` output 1: sticky flag for unmapped writes.

## Operation

**Address map** (`address[1:0]` ignored; word access only)
- RAM at `0x0000_0000` to `NUM_WORDS*4-1`.
  - Index is `address[$clog2(NUM_WORDS)+1:2]`.
- GPIO_OUT at `0x8000_0000`, read/write.
  - Low GPIO_WIDTH bits are stored.
  - Reads zero-extend.
- GPIO_IN at `0x8000_0004`, read-only.
  - Returns the synchronized `gpio_in`, zero-extended.
  - Writes are ignored and do not set `bus_error`.
- TIMER at `0x8000_0008`, read/write.
- COMPARE at `0x8000_000C`, read/write.
- All other addresses are unmapped.
  - Reads return `0x0000_0000`.
  - A write sets `bus_error` at the next edge.

**Reads**
- Purely combinational.
- No read strobe exists, so reads have no side effects.

**Writes**
- Take effect at the rising edge where `write_enable=1`.
- Read-during-write to the same location: `read_data` shows the old value in that cycle and the new value from the next cycle.

**Timer**
- 32-bit counter, +1 every cycle, wraps `0xFFFF_FFFF` to `0`.
- A write to TIMER loads `write_data`; the increment is suppressed for that cycle.
- Match: when TIMER == COMPARE (registered values), `timer_irq` is set at the next edge.
- A write to COMPARE clears `timer_irq`. If a match and a COMPARE write occur in the same cycle, the clear wins.

**Reset values**
- RAM contents are not reset.
- `gpio_out` = 0.
- TIMER = 0.
- COMPARE = `0xFFFF_FFFF`.
- `timer_irq` = 0.
- `bus_error` = 0.
- Synchronizer flops = 0.
- Reset asserted mid-operation clears all of the above immediately (asynchronously); a write in flight is discarded.

**Bus error**
- `bus_error` is sticky and cleared only by reset.

## Timing

- Read latency: 0 cycles (same cycle as `address`).
- Write latency: 1 edge.
- `gpio_out` changes at the edge that accepts the write.
- `gpio_in` to GPIO_IN readback: 2 edges, through a two-flop synchronizer.
- `timer_irq` asserts 1 edge after the cycle in which TIMER == COMPARE.
- `bus_error` asserts 1 edge after an unmapped write.

## Configuration

Macro `MEMORY_RESPONDER_TIMER_EN`:
- **Defined:** TIMER and COMPARE registers are present and behave as described above.
- **Undefined:**
  - TIMER and COMPARE addresses are unmapped: reads return 0 and writes set `bus_error`.
  - `timer_irq` is tied to 0.
  - The port list is unchanged.

## Structure

- Package `memory_map_pkg` holds:
  - Constants `GPIO_OUT_ADDRESS`, `GPIO_IN_ADDRESS`, `TIMER_ADDRESS`, `COMPARE_ADDRESS`, `RAM_BASE_ADDRESS`.
  - Enum `region_t` with values `RAM`, `GPIO_OUT`, `GPIO_IN`, `TIMER`, `COMPARE`, `UNMAPPED`, produced by a single combinational decode.
- Sub-module `synchronizer`: two-flop, parameterized width, same reset, instantiated once for `gpio_in`.

## Test plan

- **RAM write/read:** write `0xDEADBEEF` to `0x0000_0010`, then read `0x0000_0010` → `0xDEADBEEF`.
  - A same-cycle read before the edge returns the old value.
  - Reading `0x0000_0013` also returns `0xDEADBEEF`.
- **GPIO:** write `0x0000_01A5` to `0x8000_0000` → `gpio_out=0xA5` (GPIO_WIDTH=8) after 1 edge.
  - Drive `gpio_in=0x3C` → GPIO_IN reads `0x3C` after 2 edges, and still reads 0 after 1 edge.
- **Timer (TIMER_EN defined):**
  - Write TIMER=`0xFFFF_FFFE`, COMPARE=`0x0000_0001` → TIMER reads `0xFFFF_FFFE`, `0xFFFF_FFFF`, `0`, `1` on successive cycles; `timer_irq` rises 1 edge after TIMER reads `1`.
  - A COMPARE write then clears `timer_irq`.
  - A COMPARE write in the match cycle leaves `timer_irq=0`.
- **Unmapped access:**
  - Read `0x4000_0000` → `0`, `bus_error` stays 0.
  - Write to it → `bus_error=1` next edge, remains 1.
  - Write to GPIO_IN → `bus_error` unchanged.
- **Reset mid-operation:** with `gpio_out=0xFF`, `timer_irq=1`, `bus_error=1`, pulse `reset` low between edges → all three read 0 and TIMER reads 0 immediately; RAM contents are preserved.
- **TIMER_EN undefined:** write `0x8000_0008` → `bus_error=1`; read `0x8000_0008` → `0`; `timer_irq` stays 0 across 100 cycles.
